// File: rtl/mem_wait_if.sv
// ============================================================================
// Module   : mem_wait_if
// Purpose  : Request/ready bus between the CPU memory port and the memory.
//            Define MEM_WAIT_ERR_EN to add the err response bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_wait_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;
  logic              busy;
`ifdef MEM_WAIT_ERR_EN
  logic              err;

  modport master (
    output req, we, adr, wdata,
    input  ready, rdata, busy, err
  );

  modport slave (
    input  req, we, adr, wdata,
    output ready, rdata, busy, err
  );
`else
  modport master (
    output req, we, adr, wdata,
    input  ready, rdata, busy
  );

  modport slave (
    input  req, we, adr, wdata,
    output ready, rdata, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mem_wait_responder.sv
// ============================================================================
// Module   : mem_wait_responder
// Purpose  : Unified word memory answering one request at a time after a
//            programmable number of wait states. Optional MEM_WAIT_ERR_EN
//            flags misaligned / out-of-range accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wait_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  wire logic clk,
  input  wire logic reset,
  mem_wait_if.slave bus
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam int          CNT_W     = 4;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ready;
  logic               w_busy;

  logic [IDX_W-1:0]   r_cap_idx;
  logic               r_cap_we;
  logic [31:0]        r_cap_wdata;
  logic               r_cap_err;
  logic [31:0]        r_rdata;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_enter_resp;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_req_err;
  logic               w_adr_hi;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_rd_we;
  logic               w_rd_err;

  assign w_req_idx = bus.adr[IDX_W+1:2];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi_bits
      assign w_adr_hi = |bus.adr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_hi_bits
      assign w_adr_hi = 1'b0;
    end
  endgenerate

`ifdef MEM_WAIT_ERR_EN
  assign w_req_err = (bus.adr[1:0] != 2'b00) | w_adr_hi;
`else
  // Without error reporting the low and high address bits are simply ignored.
  logic w_unused_adr;
  assign w_unused_adr = ^{bus.adr[1:0], w_adr_hi};
  assign w_req_err    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_ready     = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept     = (r_state == ST_IDLE) && bus.req;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  // ---------------------------------------------------------------------------
  // Request capture; only the captured copy is used after acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cap_idx   <= w_req_idx;
      r_cap_we    <= bus.we;
      r_cap_wdata <= bus.wdata;
      r_cap_err   <= w_req_err;
    end
  end

  // With zero wait states RESP is entered on the accepting edge, so the read
  // must look at the live request rather than the not-yet-captured copy.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx : r_cap_idx;
  assign w_rd_we  = (r_state == ST_IDLE) ? bus.we    : r_cap_we;
  assign w_rd_err = (r_state == ST_IDLE) ? w_req_err : r_cap_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_enter_resp && !w_rd_we) begin
      r_rdata <= w_rd_err ? ERR_RDATA : mem[w_rd_idx];
    end
  end

  // Writes commit on the edge that ends RESP, unless reset aborts them.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_RESP) && r_cap_we && !r_cap_err) begin
      mem[r_cap_idx] <= r_cap_wdata;
    end
  end

  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;
  assign bus.rdata = r_rdata;
`ifdef MEM_WAIT_ERR_EN
  assign bus.err   = w_ready & r_cap_err;
`endif

endmodule

`default_nettype wire
